mbus_tx_sequencer: RTL

MBUS_TX_SEQUENCER -- requirements
Module: mbus_tx_sequencer

---
 rtl/mbus_tx_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mbus_tx_sequencer.sv
// MBus transmit sequencer: buffers message words, sends them as one MBus
// message with per-word handshakes, and re-sends the whole message on failure.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mbus_tx_sequencer #(
  parameter int BUF_DEPTH = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [`DATA_WIDTH-1:0]           WR_DATA,
  input  logic                             WR_EN,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   COUNT,
  output logic                             FULL,
  input  logic                             START,
  input  logic [`ADDR_WIDTH-1:0]           START_ADDR,
  input  logic                             START_PRIORITY,
  output logic                             BUSY,
  output logic                             DONE,
  output logic                             FAIL,
  output logic [`ADDR_WIDTH-1:0]           TX_ADDR,
  output logic [`DATA_WIDTH-1:0]           TX_DATA,
  output logic                             TX_REQ,
  output logic                             TX_PEND,
  output logic                             TX_PRIORITY,
  input  logic                             TX_ACK,
  input  logic                             TX_SUCC,
  input  logic                             TX_FAIL,
  output logic                             TX_RESP_ACK
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DW    = `DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_ACKD,
    S_RESULT,
    S_RESP
  } state_t;

  state_t           state;
  logic [DW-1:0]    buf_mem [BUF_DEPTH];
  logic [IDX_W-1:0] idx;
  logic [RTY_W-1:0] retry;
  logic             res_fail;

  logic             wr_ok;
  logic [CNT_W-1:0] cnt_wr;
  logic [IDX_W-1:0] idx_nxt;
  logic             more_words;
  logic             pend_nxt;
  logic [DW-1:0]    word0;
  logic             resp_in;
  logic             resp_state;

  // Next-word bookkeeping and write acceptance; a write is accepted only when idle and not full
  always_comb begin
    wr_ok      = (state == S_IDLE) && WR_EN && !FULL;
    cnt_wr     = COUNT + CNT_W'(wr_ok);
    idx_nxt    = idx + IDX_W'(1);
    more_words = (CNT_W'(idx) + CNT_W'(1)) < COUNT;
    pend_nxt   = (CNT_W'(idx) + CNT_W'(2)) < COUNT;
    // A write landing in the START cycle into an empty buffer is not in buf_mem yet
    word0      = (COUNT == '0) ? WR_DATA : buf_mem[0];
    resp_in    = TX_SUCC | TX_FAIL;
    resp_state = (state == S_SEND) || (state == S_ACKD) || (state == S_RESULT);
  end

  // Message word storage; contents are discarded logically by clearing COUNT
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      buf_mem[COUNT[IDX_W-1:0]] <= WR_DATA;
    end
  end

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      COUNT       <= '0;
      FULL        <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FAIL        <= 1'b0;
      TX_REQ      <= 1'b0;
      TX_PEND     <= 1'b0;
      TX_PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      idx         <= '0;
      retry       <= '0;
    end else begin
      DONE <= 1'b0;
      FAIL <= 1'b0;
      if (resp_state && resp_in) begin
        // Message result can arrive at any point, including mid-message
        TX_REQ      <= 1'b0;
        res_fail    <= TX_FAIL;
        TX_RESP_ACK <= 1'b1;
        state       <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            COUNT <= cnt_wr;
            FULL  <= (int'(cnt_wr) == BUF_DEPTH);
            if (START) begin
              if (cnt_wr == '0) begin
                FAIL <= 1'b1;
              end else begin
                idx         <= '0;
                retry       <= '0;
                BUSY        <= 1'b1;
                TX_REQ      <= 1'b1;
                TX_ADDR     <= START_ADDR;
                TX_PRIORITY <= START_PRIORITY;
                TX_DATA     <= word0;
                TX_PEND     <= (cnt_wr != CNT_W'(1));
                state       <= S_SEND;
              end
            end
          end
          S_SEND: begin
            if (TX_ACK) begin
              TX_REQ <= 1'b0;
              state  <= S_ACKD;
            end
          end
          S_ACKD: begin
            if (!TX_ACK) begin
              if (more_words) begin
                idx     <= idx_nxt;
                TX_REQ  <= 1'b1;
                TX_DATA <= buf_mem[idx_nxt];
                TX_PEND <= pend_nxt;
                state   <= S_SEND;
              end else begin
                state <= S_RESULT;
              end
            end
          end
          S_RESULT: begin
            state <= S_RESULT;
          end
          S_RESP: begin
            if (!resp_in) begin
              TX_RESP_ACK <= 1'b0;
              if (!res_fail) begin
                DONE  <= 1'b1;
                COUNT <= '0;
                FULL  <= 1'b0;
                BUSY  <= 1'b0;
                state <= S_IDLE;
              end else if (int'(retry) < MAX_RETRY) begin
                retry   <= retry + RTY_W'(1);
                idx     <= '0;
                TX_REQ  <= 1'b1;
                TX_DATA <= buf_mem[0];
                TX_PEND <= (COUNT != CNT_W'(1));
                state   <= S_SEND;
              end else begin
                FAIL  <= 1'b1;
                COUNT <= '0;
                FULL  <= 1'b0;
                BUSY  <= 1'b0;
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
